// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer and the gearbox FSM.
package shift_sequencer_pkg;

  localparam int unsigned GEAR_W = 3;
  localparam logic [GEAR_W-1:0] GEAR_MIN = GEAR_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StUp,
    StDown,
    StBrakeStep,
    StLockout
  } state_e;

  typedef enum logic [1:0] {
    ReqNone,
    ReqBrake,
    ReqDown,
    ReqUp
  } req_e;

  // Brake beats down beats up.
  function automatic req_e pick_req(logic brake, logic down, logic up);
    return brake ? ReqBrake : (down ? ReqDown : (up ? ReqUp : ReqNone));
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Driver pins in, gearbox command pulses and status out.
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic              shift_up_raw;
  logic              shift_down_raw;
  logic              brake_raw;
  logic              up_pulse;
  logic              down_pulse;
  logic              brake_pulse;
  logic [GEAR_W-1:0] gear;
  logic              busy;
  logic              reject;

  modport master (
    output shift_up_raw, shift_down_raw, brake_raw,
    input  up_pulse, down_pulse, brake_pulse, gear, busy, reject
  );

  modport slave (
    input  shift_up_raw, shift_down_raw, brake_raw,
    output up_pulse, down_pulse, brake_pulse, gear, busy, reject
  );

endinterface

// File: rtl/shift_sequencer_input_debouncer.sv
// 2-FF synchroniser, tick-based debounce and rising-edge detect for one raw pin.
module shift_sequencer_input_debouncer #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
          stable_d = sync2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~prev_q;

endmodule

// File: rtl/shift_sequencer.sv
// Debounces driver requests, arbitrates them, tracks the gear and issues
// single-cycle shift commands separated by a tick-counted lockout.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned LOCKOUT_TICKS  = 8,
  parameter int unsigned MAX_GEAR       = 5,
  parameter int unsigned CNT_W          = 8
) (
  input logic               clk,
  input logic               reset,
  input logic               tick,
  shift_sequencer_if.slave  bus
);

  localparam logic [GEAR_W-1:0] GearMax = GEAR_W'(MAX_GEAR);

  logic up_stable, down_stable, brake_stable;
  logic up_rise, down_rise, brake_rise;

  shift_sequencer_input_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (bus.shift_up_raw),
    .stable(up_stable),
    .rise  (up_rise)
  );

  shift_sequencer_input_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_deb_down (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (bus.shift_down_raw),
    .stable(down_stable),
    .rise  (down_rise)
  );

  shift_sequencer_input_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_deb_brake (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (bus.brake_raw),
    .stable(brake_stable),
    .rise  (brake_rise)
  );

  // Up/down act on edges only; their levels are not needed.
  logic unused_stable;
  assign unused_stable = up_stable ^ down_stable;

  state_e            state_q, state_d;
  logic [GEAR_W-1:0] gear_q, gear_d;
  logic [CNT_W-1:0]  lock_q, lock_d;
  logic              pend_up_q, pend_up_d, pend_down_q, pend_down_d;
  logic              reject_q, reject_d;
  req_e              req;

  always_comb begin
    state_d     = state_q;
    gear_d      = gear_q;
    lock_d      = lock_q;
    pend_up_d   = pend_up_q;
    pend_down_d = pend_down_q;
    reject_d    = 1'b0;
    req         = pick_req(brake_stable && (gear_q > GEAR_MIN), pend_down_q, pend_up_q);

    unique case (state_q)
      StIdle: begin
        case (req)
          ReqBrake: state_d = StBrakeStep;
          ReqDown: begin
            if (gear_q > GEAR_MIN) begin
              state_d = StDown;
            end else begin
              reject_d    = 1'b1;
              pend_down_d = 1'b0;
            end
          end
          ReqUp: begin
            if (gear_q < GearMax) begin
              state_d = StUp;
            end else begin
              reject_d  = 1'b1;
              pend_up_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
      StUp: begin
        gear_d    = gear_q + GEAR_W'(1);
        pend_up_d = 1'b0;
        lock_d    = CNT_W'(LOCKOUT_TICKS);
        state_d   = StLockout;
      end
      StDown, StBrakeStep: begin
        gear_d      = gear_q - GEAR_W'(1);
        pend_down_d = 1'b0;
        if (state_q == StBrakeStep) pend_up_d = 1'b0;
        lock_d      = CNT_W'(LOCKOUT_TICKS);
        state_d     = StLockout;
      end
      StLockout: begin
        if (tick) begin
          lock_d = lock_q - CNT_W'(1);
          if (lock_q == CNT_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // New edges are captured in every state; a brake edge cancels a queued upshift.
    if (up_rise)    pend_up_d   = 1'b1;
    if (down_rise)  pend_down_d = 1'b1;
    if (brake_rise) pend_up_d   = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      gear_q      <= GEAR_MIN;
      lock_q      <= '0;
      pend_up_q   <= 1'b0;
      pend_down_q <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gear_q      <= gear_d;
      lock_q      <= lock_d;
      pend_up_q   <= pend_up_d;
      pend_down_q <= pend_down_d;
      reject_q    <= reject_d;
    end
  end

  assign bus.up_pulse    = (state_q == StUp);
  assign bus.down_pulse  = (state_q == StDown) || (state_q == StBrakeStep);
  assign bus.brake_pulse = brake_rise;
  assign bus.gear        = gear_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.reject      = reject_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, corner sequences and
// random stimulus compared cycle by cycle against a behavioural model.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int DEB    = 4;
  localparam int LOCK   = 8;
  localparam int MAXG   = 5;
  localparam int TDIV   = 4;
  localparam int SETTLE = 20;

  logic clk = 1'b0;
  logic reset;
  logic tick;

  shift_sequencer_if bus ();

  shift_sequencer #(
    .DEBOUNCE_TICKS(DEB),
    .LOCKOUT_TICKS (LOCK),
    .MAX_GEAR      (MAXG),
    .CNT_W         (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  task automatic check(string name, int act, int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per input: index 0 up, 1 down, 2 brake.
  bit m_s1[3], m_s2[3], m_stab[3], m_prev[3];
  int m_cnt[3];
  bit m_pu, m_pd, m_brk, m_rej;
  int m_gear, m_phase, m_lock;  // phase: 0 idle, 1 upshift, 2 downshift, 3 lockout

  task automatic model_step();
    bit raw[3];
    bit rise[3];
    bit pu, pd;
    raw[0] = bus.shift_up_raw;
    raw[1] = bus.shift_down_raw;
    raw[2] = bus.brake_raw;
    for (int i = 0; i < 3; i++) rise[i] = m_stab[i] && !m_prev[i];
    pu    = m_pu;
    pd    = m_pd;
    m_rej = 1'b0;
    case (m_phase)
      0: begin
        if (m_stab[2] && m_gear > 1) begin
          m_phase = 2; m_brk = 1'b1;
        end else if (m_pd) begin
          if (m_gear > 1) begin m_phase = 2; m_brk = 1'b0; end
          else begin m_rej = 1'b1; pd = 1'b0; end
        end else if (m_pu) begin
          if (m_gear < MAXG) m_phase = 1;
          else begin m_rej = 1'b1; pu = 1'b0; end
        end
      end
      1: begin m_gear++; pu = 1'b0; m_lock = LOCK; m_phase = 3; end
      2: begin
        m_gear--; pd = 1'b0;
        if (m_brk) pu = 1'b0;
        m_lock = LOCK; m_phase = 3;
      end
      default: if (tick) begin
        m_lock--;
        if (m_lock == 0) m_phase = 0;
      end
    endcase
    if (rise[0]) pu = 1'b1;
    if (rise[1]) pd = 1'b1;
    if (rise[2]) pu = 1'b0;
    m_pu = pu;
    m_pd = pd;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = m_stab[i];
      if (tick) begin
        if (m_s2[i] != m_stab[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin m_stab[i] = m_s2[i]; m_cnt[i] = 0; end
        end else begin
          m_cnt[i] = 0;
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_stab[i] = 1'b0; m_prev[i] = 1'b0; m_cnt[i] = 0;
      end
      m_pu = 1'b0; m_pd = 1'b0; m_brk = 1'b0; m_rej = 1'b0;
      m_gear = 1; m_phase = 0; m_lock = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle checker and pulse monitor ----------------
  int cyc = 0;
  int n_up, n_down, n_brake, n_rej;
  int t_up, t_down, g_at_up;

  function automatic logic [7:0] dut_vec();
    return {bus.up_pulse, bus.down_pulse, bus.brake_pulse, bus.busy, bus.reject, bus.gear};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      logic [7:0] exp_v;
      cyc++;
      exp_v = {m_phase == 1, m_phase == 2, m_stab[2] && !m_prev[2], m_phase != 0, m_rej,
               3'(m_gear)};
      check("model {up,down,brake,busy,reject,gear}", int'(dut_vec()), int'(exp_v));
      if (bus.up_pulse) n_up++;
      if (bus.down_pulse) n_down++;
      if (bus.brake_pulse) n_brake++;
      if (bus.reject) n_rej++;
      if (bus.down_pulse && t_down < 0) t_down = cyc;
      if (bus.up_pulse && t_up < 0) begin t_up = cyc; g_at_up = int'(bus.gear); end
    end
  end

  // ---------------- stimulus helpers ----------------
  int tdiv = 0;
  bit rand_tick = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    tdiv++;
    if (rand_tick) tick = ($urandom_range(0, 2) == 0);
    else tick = (tdiv % TDIV == 0);
  endtask

  task automatic run_ticks(int n);
    repeat (n * TDIV) step();
  endtask

  task automatic set_raw(bit up, bit down, bit brake);
    bus.shift_up_raw   = up;
    bus.shift_down_raw = down;
    bus.brake_raw      = brake;
  endtask

  typedef struct {
    bit up;
    bit down;
    bit brake;
    int hold;
    int gear;
    int n_up;
    int n_down;
    int n_brake;
    int n_rej;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit seen;
    reset = 1'b1;
    tick  = 1'b0;
    set_raw(0, 0, 0);
    n_up = 0; n_down = 0; n_brake = 0; n_rej = 0;
    t_up = -1; t_down = -1; g_at_up = 0;
    #1;
    check("reset outputs", int'(dut_vec()), 8'h01);
    repeat (3) step();
    check("reset outputs held", int'(dut_vec()), 8'h01);
    reset = 1'b0;

    //              up dn br hold gear nu nd nb nr
    vecs.push_back('{1, 0, 0, 6,   2,   1, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 2,   2,   0, 0, 0, 0});  // glitch, filtered out
    vecs.push_back('{0, 1, 0, 6,   1,   0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 6,   2,   1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 6,   3,   1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 6,   4,   1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 6,   5,   1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 6,   5,   0, 0, 0, 1});  // at top gear
    vecs.push_back('{0, 1, 0, 6,   4,   0, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 60,  1,   0, 3, 1, 0});  // held brake walks down
    vecs.push_back('{0, 1, 0, 6,   1,   0, 0, 0, 1});  // at bottom gear
    vecs.push_back('{1, 0, 0, 6,   2,   1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 6,   3,   1, 0, 0, 0});

    foreach (vecs[i]) begin
      n_up = 0; n_down = 0; n_brake = 0; n_rej = 0;
      set_raw(vecs[i].up, vecs[i].down, vecs[i].brake);
      run_ticks(vecs[i].hold);
      set_raw(0, 0, 0);
      run_ticks(SETTLE);
      check($sformatf("vec%0d gear", i), int'(bus.gear), vecs[i].gear);
      check($sformatf("vec%0d up_pulses", i), n_up, vecs[i].n_up);
      check($sformatf("vec%0d down_pulses", i), n_down, vecs[i].n_down);
      check($sformatf("vec%0d brake_pulses", i), n_brake, vecs[i].n_brake);
      check($sformatf("vec%0d rejects", i), n_rej, vecs[i].n_rej);
    end

    // Simultaneous up and down at gear 3: down first, up after the lockout.
    t_up = -1; t_down = -1;
    set_raw(1, 1, 0);
    for (int k = 0; k < 400 && t_up < 0; k++) step();
    check("simul up issued", int'(t_up >= 0), 1);
    check("simul down before up", int'(t_down >= 0 && t_down < t_up), 1);
    check("simul lockout gap", int'(t_up - t_down >= (LOCK - 1) * TDIV), 1);
    check("simul gear at up pulse", g_at_up, 2);
    set_raw(0, 0, 0);
    run_ticks(SETTLE);
    check("simul final gear", int'(bus.gear), 3);

    // Reset in the middle of a lockout acts without a clock edge.
    set_raw(1, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step();
      seen = bus.up_pulse;
    end
    check("lockout up issued", int'(seen), 1);
    set_raw(0, 0, 0);
    repeat (5) step();
    check("lockout busy", int'(bus.busy), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async reset outputs", int'(dut_vec()), 8'h01);
    repeat (3) step();
    @(negedge clk);
    #2 reset = 1'b0;
    run_ticks(4);
    check("post reset gear", int'(bus.gear), 1);

    // Random pins and irregular ticks against the model.
    rand_tick = 1'b1;
    for (int s = 0; s < 150; s++) begin
      set_raw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(1, 40)) step();
    end
    set_raw(0, 0, 0);
    repeat (200) step();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
